alu_req_issuer: RTL and testbench

- Synthesizable initiator for the ALU operand/result interface.
- Accepts packed operation requests on a valid/ready port and buffers them in a small FIFO.
- Drives one request at a time onto the ALU input pins, waits the command-dependent latency, and captures the ALU flags and result.
- Returns the captured result on a valid/ready response port; sits between a host sequencer and the ALU.

---
 rtl/alu_req_issuer.sv | 194 +++++++++++++++++++
 tb/tb_alu_req_issuer.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_req_issuer.sv
// alu_req_issuer
//   Sits between a host sequencer and the ALU. Operation requests arrive on a
//   valid/ready port and are buffered in a small FIFO. One request at a time
//   is driven onto the ALU pins. The block waits the command-dependent latency,
//   captures the result and the flags, and returns them on a valid/ready
//   response port. Responses come back in request order, and only one
//   operation is outstanding at a time.
//
// Ports
//   CLK, RST               clock (rising edge), synchronous active-high reset
//   req_valid/req_ready    request handshake; req_ready = FIFO not full
//   req_mode, req_cmd,     packed request fields, forwarded unmodified
//   req_inp_valid, req_opa,
//   req_opb, req_cin
//   ALU_CE                 ALU clock enable, high from issue until capture
//   ALU_MODE..ALU_CIN      registered ALU request pins
//   ALU_RES, ALU_ERR..E    ALU result and flags, sampled at capture
//   rsp_valid/rsp_ready    response handshake
//   rsp_res, rsp_flags     captured result, flags {err,oflow,cout,g,l,e}
//   busy                   FSM is not in IDLE
//   fifo_count             FIFO occupancy
//
// State   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for a queued request; pops and issues when one exists
// ISSUE   | first ALU_CE cycle, request pins stable
// WAIT    | latency down-counter running, pins stable, ALU_CE high
// HOLD    | response captured, waiting for rsp_ready
module alu_req_issuer #(
  parameter int WIDTH      = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int LAT_NORM   = 1,
  parameter int LAT_MUL    = 2
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic                          req_mode,
  input  logic [3:0]                    req_cmd,
  input  logic [1:0]                    req_inp_valid,
  input  logic [WIDTH-1:0]              req_opa,
  input  logic [WIDTH-1:0]              req_opb,
  input  logic                          req_cin,
  output logic                          ALU_CE,
  output logic                          ALU_MODE,
  output logic [3:0]                    ALU_CMD,
  output logic [1:0]                    ALU_INP_VALID,
  output logic [WIDTH-1:0]              ALU_OPA,
  output logic [WIDTH-1:0]              ALU_OPB,
  output logic                          ALU_CIN,
  input  logic [2*WIDTH-1:0]            ALU_RES,
  input  logic                          ALU_ERR,
  input  logic                          ALU_OFLOW,
  input  logic                          ALU_COUT,
  input  logic                          ALU_G,
  input  logic                          ALU_L,
  input  logic                          ALU_E,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [2*WIDTH-1:0]            rsp_res,
  output logic [5:0]                    rsp_flags,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int AW      = $clog2(FIFO_DEPTH);
  localparam int EW      = 2*WIDTH + 8;
  localparam int LAT_MAX = (LAT_MUL > LAT_NORM) ? LAT_MUL : LAT_NORM;
  localparam int CW      = $clog2(LAT_MAX + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_HOLD  = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic [EW-1:0]  mem [FIFO_DEPTH];
  logic [AW-1:0]  wr_ptr, rd_ptr;
  logic [AW:0]    count;
  logic           full;
  logic           push, pop, capture, rsp_done;
  logic [CW-1:0]  lat_cnt;

  logic             h_mode;
  logic [3:0]       h_cmd;
  logic [1:0]       h_iv;
  logic [WIDTH-1:0] h_opa, h_opb;
  logic             h_cin;
  logic             h_is_mul;

  // Full comes from the registered occupancy, so a pop in the same cycle
  // never opens a slot for a push. Ready is forced low while reset is held.
  assign full       = (count == (AW+1)'(FIFO_DEPTH));
  assign req_ready  = !RST && !full;
  assign push       = req_valid && req_ready;
  assign fifo_count = count;
  assign busy       = (state != S_IDLE);

  assign {h_mode, h_cmd, h_iv, h_opa, h_opb, h_cin} = mem[rd_ptr];
  assign h_is_mul = h_mode && ((h_cmd == 4'd9) || (h_cmd == 4'd10));

  always_ff @(posedge CLK) begin
    if (push) begin
      mem[wr_ptr] <= {req_mode, req_cmd, req_inp_valid, req_opa, req_opb, req_cin};
    end
  end

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    capture   = 1'b0;
    rsp_done  = 1'b0;
    case (state)
      S_IDLE: begin
        if (count != '0) begin
          pop       = 1'b1;
          state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: state_nxt = S_WAIT;
      S_WAIT: begin
        // Terminal count: the counter reaches zero on this edge.
        if (lat_cnt == CW'(1)) begin
          capture   = 1'b1;
          state_nxt = S_HOLD;
        end
      end
      S_HOLD: begin
        if (rsp_valid && rsp_ready) begin
          rsp_done  = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state         <= S_IDLE;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      lat_cnt       <= '0;
      ALU_CE        <= 1'b0;
      ALU_MODE      <= 1'b0;
      ALU_CMD       <= '0;
      ALU_INP_VALID <= '0;
      ALU_OPA       <= '0;
      ALU_OPB       <= '0;
      ALU_CIN       <= 1'b0;
      rsp_valid     <= 1'b0;
      rsp_res       <= '0;
      rsp_flags     <= '0;
    end else begin
      state <= state_nxt;

      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase

      if (pop) begin
        ALU_CE        <= 1'b1;
        ALU_MODE      <= h_mode;
        ALU_CMD       <= h_cmd;
        ALU_INP_VALID <= h_iv;
        ALU_OPA       <= h_opa;
        ALU_OPB       <= h_opb;
        ALU_CIN       <= h_cin;
        lat_cnt       <= h_is_mul ? CW'(LAT_MUL) : CW'(LAT_NORM);
      end

      if (state == S_WAIT) lat_cnt <= lat_cnt - CW'(1);

      if (capture) begin
        ALU_CE    <= 1'b0;
        rsp_valid <= 1'b1;
        rsp_res   <= ALU_RES;
        rsp_flags <= {ALU_ERR, ALU_OFLOW, ALU_COUT, ALU_G, ALU_L, ALU_E};
      end

      if (rsp_done) rsp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_req_issuer.sv
module tb_alu_req_issuer;

  localparam int W     = 8;
  localparam int DEPTH = 4;

  typedef struct packed {
    logic       mode;
    logic [3:0] cmd;
    logic [1:0] iv;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
  } req_t;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  logic req_valid, req_ready, req_mode, req_cin;
  logic [3:0] req_cmd;
  logic [1:0] req_inp_valid;
  logic [W-1:0] req_opa, req_opb;
  logic ALU_CE, ALU_MODE, ALU_CIN;
  logic [3:0] ALU_CMD;
  logic [1:0] ALU_INP_VALID;
  logic [W-1:0] ALU_OPA, ALU_OPB;
  logic [2*W-1:0] ALU_RES;
  logic ALU_ERR, ALU_OFLOW, ALU_COUT, ALU_G, ALU_L, ALU_E;
  logic rsp_valid, rsp_ready, busy;
  logic [2*W-1:0] rsp_res;
  logic [5:0] rsp_flags;
  logic [$clog2(DEPTH):0] fifo_count;

  always #5 CLK = ~CLK;

  alu_req_issuer #(.WIDTH(W), .FIFO_DEPTH(DEPTH), .LAT_NORM(1), .LAT_MUL(2)) dut (
    .CLK(CLK), .RST(RST),
    .req_valid(req_valid), .req_ready(req_ready), .req_mode(req_mode),
    .req_cmd(req_cmd), .req_inp_valid(req_inp_valid), .req_opa(req_opa),
    .req_opb(req_opb), .req_cin(req_cin),
    .ALU_CE(ALU_CE), .ALU_MODE(ALU_MODE), .ALU_CMD(ALU_CMD),
    .ALU_INP_VALID(ALU_INP_VALID), .ALU_OPA(ALU_OPA), .ALU_OPB(ALU_OPB),
    .ALU_CIN(ALU_CIN), .ALU_RES(ALU_RES), .ALU_ERR(ALU_ERR),
    .ALU_OFLOW(ALU_OFLOW), .ALU_COUT(ALU_COUT), .ALU_G(ALU_G), .ALU_L(ALU_L),
    .ALU_E(ALU_E), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_res(rsp_res), .rsp_flags(rsp_flags), .busy(busy), .fifo_count(fifo_count)
  );

  int checks  = 0;
  int errors  = 0;
  int printed = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (printed < 40) begin
        printed++;
        $display("FAIL %s: actual=0x%0h required=0x%0h (t=%0t)", name, act, exp, $time);
      end
    end
  endtask

  task automatic fail_timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out waiting for DUT (t=%0t)", name, $time);
  endtask

  function automatic req_t mk(input logic mode, input logic [3:0] cmd, input logic [1:0] iv,
                              input logic [7:0] a, input logic [7:0] b, input logic cin);
    req_t r;
    r.mode = mode; r.cmd = cmd; r.iv = iv; r.a = a; r.b = b; r.cin = cin;
    return r;
  endfunction

  // Bench-side ALU: result {err,oflow,cout,g,l,e,res[15:0]}.
  function automatic logic [21:0] alu_fn(input req_t r);
    logic [15:0] res;
    logic err, ofl, cout, g, l, e;
    res = '0; err = 0; ofl = 0; cout = 0; g = 0; l = 0; e = 0;
    if (r.iv != 2'b11) err = 1'b1;
    else if (r.mode) begin
      case (r.cmd)
        4'd0:  begin res = 16'(r.a) + 16'(r.b); cout = res[8]; end
        4'd1:  begin res = 16'(r.a - r.b); ofl = (r.a < r.b); end
        4'd2:  begin res = 16'(r.a) + 16'(r.b) + 16'(r.cin); cout = res[8]; end
        4'd8:  begin e = (r.a == r.b); g = (r.a > r.b); l = (r.a < r.b); end
        4'd9:  res = (16'(r.a) + 16'd1) * (16'(r.b) + 16'd1);
        4'd10: res = 16'({r.a, 1'b0}) * 16'(r.b);
        default: err = 1'b1;
      endcase
    end else begin
      case (r.cmd)
        4'd0:  res = {8'h00, r.a & r.b};
        4'd1:  res = {8'h00, r.a | r.b};
        4'd2:  res = {8'h00, r.a ^ r.b};
        default: err = 1'b1;
      endcase
    end
    return {err, ofl, cout, g, l, e, res};
  endfunction

  function automatic int lat_of(input req_t r);
    return (r.mode && (r.cmd == 4'd9 || r.cmd == 4'd10)) ? 2 : 1;
  endfunction

  // ALU stand-in: garbage whenever ALU_CE is low, so late captures are visible.
  req_t        pin_req;
  logic [21:0] junk;
  assign pin_req = {ALU_MODE, ALU_CMD, ALU_INP_VALID, ALU_OPA, ALU_OPB, ALU_CIN};
  assign {ALU_ERR, ALU_OFLOW, ALU_COUT, ALU_G, ALU_L, ALU_E, ALU_RES} =
         ALU_CE ? alu_fn(pin_req) : junk;

  initial begin
    junk = '0;
    forever begin
      @(negedge CLK);
      junk = 22'($urandom);
    end
  end

  // Reference model: request queue plus issue timestamp and held response.
  req_t        m_fifo[$];
  req_t        m_cur;
  logic [21:0] m_rsp;
  bit          m_active, m_hold, m_known;
  int          m_issue_n, edge_n;
  int          sz0;
  bit          act0, hold0;

  initial begin
    m_known = 0; m_active = 0; m_hold = 0; edge_n = 0; m_issue_n = 0;
    m_rsp = '0; m_cur = '0;
    forever begin
      @(posedge CLK);
      if (RST) begin
        m_fifo.delete();
        m_active = 0;
        m_hold   = 0;
        m_known  = 1;
      end else if (m_known) begin
        sz0   = m_fifo.size();
        act0  = m_active;
        hold0 = m_hold;
        if (hold0 && rsp_ready) m_hold = 0;
        if (act0 && (edge_n - m_issue_n) == lat_of(m_cur) + 1) begin
          m_rsp    = alu_fn(m_cur);
          m_hold   = 1;
          m_active = 0;
        end
        if (!act0 && !hold0 && sz0 > 0) begin
          m_cur     = m_fifo.pop_front();
          m_active  = 1;
          m_issue_n = edge_n;
        end
        if (req_valid && sz0 < DEPTH)
          m_fifo.push_back(mk(req_mode, req_cmd, req_inp_valid, req_opa, req_opb, req_cin));
      end
      edge_n++;
    end
  end

  // Per-cycle comparison against the model.
  initial begin
    forever begin
      @(negedge CLK);
      if (m_known) begin
        chk("req_ready",  64'(req_ready),  64'(!RST && m_fifo.size() < DEPTH));
        chk("fifo_count", 64'(fifo_count), 64'(m_fifo.size()));
        chk("alu_ce",     64'(ALU_CE),     64'(m_active));
        chk("busy",       64'(busy),       64'(m_active || m_hold));
        chk("rsp_valid",  64'(rsp_valid),  64'(m_hold));
        if (m_active) chk("alu_pins", 64'(pin_req), 64'(m_cur));
        if (m_hold)   chk("rsp_data", 64'({rsp_flags, rsp_res}), 64'(m_rsp));
      end
    end
  end

  task automatic drive(input req_t r, input logic v);
    req_valid = v; req_mode = r.mode; req_cmd = r.cmd; req_inp_valid = r.iv;
    req_opa = r.a; req_opb = r.b; req_cin = r.cin;
  endtask

  // Push one request while idle with rsp_ready high, then pin latency and data.
  task automatic directed(input string name, input req_t r, input logic [21:0] exp, input int lat);
    int t_ce, t_rv;
    t_ce = -1; t_rv = -1;
    @(posedge CLK); #1 drive(r, 1'b1);
    @(posedge CLK); #1 req_valid = 1'b0;
    for (int n = 0; n < 30 && t_rv < 0; n++) begin
      @(negedge CLK);
      if (t_ce < 0 && ALU_CE) t_ce = n;
      if (t_rv < 0 && rsp_valid) begin
        t_rv = n;
        chk({name, "_ce_low_at_rsp"}, 64'(ALU_CE), 64'(0));
        chk({name, "_rsp"}, 64'({rsp_flags, rsp_res}), 64'(exp));
      end
    end
    if (t_rv < 0) fail_timeout(name);
    else begin
      chk({name, "_first_ce"}, 64'(t_ce), 64'(1));
      chk({name, "_lat"}, 64'(t_rv - t_ce), 64'(lat + 1));
    end
    @(negedge CLK);
    chk({name, "_idle_after"}, 64'(busy), 64'(0));
  endtask

  int got;

  initial begin
    drive('0, 1'b0);
    rsp_ready = 1'b0;
    RST = 1'b1;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk("rst_req_ready", 64'(req_ready), 64'(0));
    chk("rst_count",     64'(fifo_count), 64'(0));
    chk("rst_ce",        64'(ALU_CE), 64'(0));
    chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
    chk("rst_busy",      64'(busy), 64'(0));
    chk("rst_pins",      64'(pin_req), 64'(0));
    chk("rst_rsp",       64'({rsp_flags, rsp_res}), 64'(0));
    @(posedge CLK); #1 RST = 1'b0; rsp_ready = 1'b1;
    @(negedge CLK);
    chk("post_rst_req_ready", 64'(req_ready), 64'(1));

    directed("add_0f_01",  mk(1, 4'd0, 2'b11, 8'h0F, 8'h01, 0), {6'b000000, 16'h0010}, 1);
    directed("add_ff_01",  mk(1, 4'd0, 2'b11, 8'hFF, 8'h01, 0), {6'b001000, 16'h0100}, 1);
    directed("mul_3_4",    mk(1, 4'd9, 2'b11, 8'd3,  8'd4,  0), {6'b000000, 16'd20},   2);
    directed("iv_00",      mk(1, 4'd0, 2'b00, 8'd5,  8'd6,  0), {6'b100000, 16'h0000}, 1);

    // Backpressure: five back-to-back pushes with the response port stalled.
    @(posedge CLK); #1 rsp_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(mk(1, 4'd0, 2'b11, 8'(i + 1), 8'h10, 0), 1'b1);
      @(posedge CLK); #1;
    end
    req_valid = 1'b0;
    repeat (5) @(negedge CLK);
    chk("bp_count",     64'(fifo_count), 64'(4));
    chk("bp_req_ready", 64'(req_ready), 64'(0));
    chk("bp_rsp_valid", 64'(rsp_valid), 64'(1));
    @(posedge CLK); #1 rsp_ready = 1'b1;
    got = 0;
    for (int n = 0; n < 100 && got < 5; n++) begin
      @(negedge CLK);
      if (rsp_valid) begin
        chk("bp_order", 64'({rsp_flags, rsp_res}), 64'({6'b0, 16'(got + 17)}));
        got++;
      end
    end
    if (got < 5) fail_timeout("bp_drain");
    repeat (3) @(negedge CLK);

    // Reset while a multiply is in WAIT with two requests queued.
    for (int i = 0; i < 3; i++) begin
      @(posedge CLK); #1 drive(mk(1, 4'd9, 2'b11, 8'(i), 8'd2, 0), 1'b1);
    end
    @(posedge CLK); #1 req_valid = 1'b0; RST = 1'b1;
    @(negedge CLK);
    chk("wait_count", 64'(fifo_count), 64'(2));
    chk("wait_ce",    64'(ALU_CE), 64'(1));
    @(negedge CLK);
    chk("mid_rst_ce",        64'(ALU_CE), 64'(0));
    chk("mid_rst_rsp_valid", 64'(rsp_valid), 64'(0));
    chk("mid_rst_count",     64'(fifo_count), 64'(0));
    @(posedge CLK); #1 RST = 1'b0;
    for (int n = 0; n < 10; n++) begin
      @(negedge CLK);
      chk("no_stale_rsp", 64'(rsp_valid), 64'(0));
    end

    // Randomized traffic with occasional resets.
    for (int n = 0; n < 2000; n++) begin
      @(posedge CLK); #1;
      drive(mk(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
               ($urandom_range(0, 9) == 0) ? 2'($urandom_range(0, 2)) : 2'b11,
               8'($urandom), 8'($urandom), 1'($urandom_range(0, 1))),
            $urandom_range(0, 99) < 60);
      rsp_ready = ($urandom_range(0, 99) < 70);
      RST = ($urandom_range(0, 499) == 0);
    end
    @(posedge CLK); #1 req_valid = 1'b0; rsp_ready = 1'b1; RST = 1'b0;
    repeat (60) @(negedge CLK);
    chk("drain_count", 64'(fifo_count), 64'(0));
    chk("drain_busy",  64'(busy), 64'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1);
  end

endmodule
